pe_context_sequencer: RTL and testbench
=======================================

// Module: pe_context_sequencer
// PURPOSE
//  Upstream issue stage for one PE ALU. Stores per-PE contexts (ALU config word + immediate)
//  written during configuration, then on Start replays them in order, one per cycle.
//  Drives the ALU's En/Finish/CFG/IM inputs with loop-count control and a stall hook.
//  Sits between the array-level config/control bus and the ALU of each PE.
// PARAMETERS
//  CTX_DEPTH   16   number of context entries (power of 2)
//  CTX_AW      4    log2(CTX_DEPTH)
//  CFG_W       24   ALU config word width (= ALU_CFG_BITS)
//  IM_W        32   immediate width (= CTX_IM_BITS)
//  LOOP_W      16   loop-iteration counter width
// PORTS
//  CLK             in   1            clock, rising edge
//  RST             in   1            asynchronous reset, active-low
//  Mode_in         in   1            0 = configure, 1 = execute
//  Ctx_wr_en_in    in   1            context write strobe
//  Ctx_wr_addr_in  in   CTX_AW       context write address
//  Ctx_wr_data_in  in   CFG_W+IM_W   {CFG, IM} to store
//  Start_in        in   1            one-cycle start pulse
//  Ctx_last_in     in   CTX_AW       index of last context per iteration
//  Loop_cnt_in     in   LOOP_W       iterations to run (0 treated as 1)
//  Stall_in        in   1            hold issue this cycle
//  En_out          out  1            context valid to ALU
//  Finish_out      out  1            marks final context of final iteration
//  CFG_out         out  CFG_W        ALU config word
//  IM_out          out  IM_W         ALU immediate
//  Ctx_idx_out     out  CTX_AW       index of context on CFG_out/IM_out
//  Busy_out        out  1            high in RUN
//  Done_out        out  1            one-cycle pulse after normal completion
// BEHAVIOUR
//  Reset (RST=0, any time, incl. mid-run): state=IDLE; all outputs 0; pc, iter, latched
//   Ctx_last/Loop_cnt = 0; all context entries = 0.
//  Storage: write at rising edge when Ctx_wr_en_in=1 and state=IDLE; writes during RUN ignored.
//  States: IDLE, RUN.
//   IDLE: En_out=Finish_out=Busy_out=0; CFG_out/IM_out/Ctx_idx_out = 0.
//     Start_in=1 & Mode_in=1 -> RUN; latch Ctx_last_in and max(Loop_cnt_in,1); pc=0, iter=1.
//     Start_in with Mode_in=0 ignored.
//   RUN, Stall_in=0: register CFG/IM = mem[pc], Ctx_idx_out=pc, En_out=1.
//     pc==last & iter==loops: Finish_out=1 same cycle, next state IDLE, Done_out=1 next cycle.
//     pc==last otherwise: pc=0, iter+1. Else pc+1.
//   RUN, Stall_in=1: En_out=0, Finish_out=0; CFG/IM/Ctx_idx hold; pc/iter hold.
//   RUN, Mode_in=0 (abort, priority over stall/issue): -> IDLE next edge; outputs cleared.
//     No Finish_out, no Done_out.
//  Start_in during RUN ignored; Ctx_last_in/Loop_cnt_in changes during RUN ignored.
//  Latency: Start sampled at edge t -> first En_out=1 (ctx 0) after edge t+1.
//  Issue count: (last+1)*loops En_out pulses; stalls only insert gaps.
//  Done_out: high exactly one cycle, the cycle after the Finish_out cycle, with Busy_out=0.
//  Context write at address N in the Start cycle is stored (IDLE) and visible to the run.
//  Counters never wrap: iter compare is exact; LOOP_W max value fully supported.
//  All outputs registered; no combinational path from inputs to outputs.
// TESTING
//  Load ctx0..2 = {CFG=i+1, IM=0x10*i}, last=2, loops=1, Start -> En 3 cycles,
//   CFG 1,2,3; Finish_out on ctx 2; Done_out next cycle.
//  last=1, loops=3 -> 6 issues, idx 0,1,0,1,0,1; Finish_out only on 6th; loops=0 -> 2 issues.
//  Stall_in high for cycles 2-3 of a 4-ctx run -> En gaps, outputs held, still 4 issues in order,
//   Finish on idx 3.
//  Mode_in dropped after 2nd issue -> IDLE next cycle, all outputs 0, no Finish/Done.
//   Then writes accepted.
//  Ctx write attempted during RUN to addr 0 (0xAAAA) -> rerun shows original ctx0.
//   Start during RUN ignored.
//  RST low mid-run -> outputs 0 asynchronously; after release, replay shows all contexts = 0.

Source files
------------

// File: rtl/pe_context_sequencer.sv
// Context store and in-order replay issue stage for one PE ALU,
// with loop count, stall hold and mode-drop abort.
module pe_context_sequencer #(
    parameter int CTX_DEPTH = 16,
    parameter int CTX_AW    = 4,
    parameter int CFG_W     = 24,
    parameter int IM_W      = 32,
    parameter int LOOP_W    = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Mode_in,
    input  logic                  Ctx_wr_en_in,
    input  logic [CTX_AW-1:0]     Ctx_wr_addr_in,
    input  logic [CFG_W+IM_W-1:0] Ctx_wr_data_in,
    input  logic                  Start_in,
    input  logic [CTX_AW-1:0]     Ctx_last_in,
    input  logic [LOOP_W-1:0]     Loop_cnt_in,
    input  logic                  Stall_in,
    output logic                  En_out,
    output logic                  Finish_out,
    output logic [CFG_W-1:0]      CFG_out,
    output logic [IM_W-1:0]       IM_out,
    output logic [CTX_AW-1:0]     Ctx_idx_out,
    output logic                  Busy_out,
    output logic                  Done_out
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                  state;
    logic [CFG_W+IM_W-1:0]   mem [CTX_DEPTH];
    logic [CFG_W+IM_W-1:0]   rd;
    logic [CTX_AW-1:0]       pc;
    logic [CTX_AW-1:0]       last;
    logic [LOOP_W-1:0]       iter;
    logic [LOOP_W-1:0]       loops;
    logic                    wr_ok;
    logic                    at_last;
    logic                    at_final;

    assign wr_ok    = Ctx_wr_en_in && (state == IDLE);
    assign rd       = mem[pc];
    assign at_last  = (pc == last);
    assign at_final = at_last && (iter == loops);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < CTX_DEPTH; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[Ctx_wr_addr_in] <= Ctx_wr_data_in;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            pc          <= '0;
            last        <= '0;
            iter        <= '0;
            loops       <= '0;
            En_out      <= 1'b0;
            Finish_out  <= 1'b0;
            CFG_out     <= '0;
            IM_out      <= '0;
            Ctx_idx_out <= '0;
            Busy_out    <= 1'b0;
            Done_out    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    En_out      <= 1'b0;
                    Finish_out  <= 1'b0;
                    CFG_out     <= '0;
                    IM_out      <= '0;
                    Ctx_idx_out <= '0;
                    Busy_out    <= 1'b0;
                    // Finish_out is only ever set by the final issue
                    Done_out    <= Finish_out;
                    if (Start_in && Mode_in) begin
                        state    <= RUN;
                        Busy_out <= 1'b1;
                        last     <= Ctx_last_in;
                        loops    <= (Loop_cnt_in == '0) ? LOOP_W'(1) : Loop_cnt_in;
                        pc       <= '0;
                        iter     <= LOOP_W'(1);
                    end
                end
                RUN: begin
                    Done_out <= 1'b0;
                    if (!Mode_in) begin
                        state       <= IDLE;
                        En_out      <= 1'b0;
                        Finish_out  <= 1'b0;
                        CFG_out     <= '0;
                        IM_out      <= '0;
                        Ctx_idx_out <= '0;
                        Busy_out    <= 1'b0;
                    end else if (Stall_in) begin
                        En_out     <= 1'b0;
                        Finish_out <= 1'b0;
                    end else begin
                        En_out      <= 1'b1;
                        CFG_out     <= rd[CFG_W+IM_W-1:IM_W];
                        IM_out      <= rd[IM_W-1:0];
                        Ctx_idx_out <= pc;
                        if (at_final) begin
                            Finish_out <= 1'b1;
                            Busy_out   <= 1'b0;
                            state      <= IDLE;
                        end else if (at_last) begin
                            Finish_out <= 1'b0;
                            pc         <= '0;
                            iter       <= iter + LOOP_W'(1);
                        end else begin
                            Finish_out <= 1'b0;
                            pc         <= pc + CTX_AW'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_context_sequencer.sv
// Randomized bench for pe_context_sequencer against a queue-based
// model of the expected issue order and context contents.
module tb_pe_context_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Mode_in;
    logic        Ctx_wr_en_in;
    logic [3:0]  Ctx_wr_addr_in;
    logic [55:0] Ctx_wr_data_in;
    logic        Start_in;
    logic [3:0]  Ctx_last_in;
    logic [15:0] Loop_cnt_in;
    logic        Stall_in;
    logic        En_out;
    logic        Finish_out;
    logic [23:0] CFG_out;
    logic [31:0] IM_out;
    logic [3:0]  Ctx_idx_out;
    logic        Busy_out;
    logic        Done_out;

    logic [55:0] mm [16];
    logic [63:0] obs;
    int          total = 0;
    int          bad = 0;

    pe_context_sequencer dut (
        .CLK(CLK), .RST(RST), .Mode_in(Mode_in),
        .Ctx_wr_en_in(Ctx_wr_en_in), .Ctx_wr_addr_in(Ctx_wr_addr_in),
        .Ctx_wr_data_in(Ctx_wr_data_in), .Start_in(Start_in),
        .Ctx_last_in(Ctx_last_in), .Loop_cnt_in(Loop_cnt_in),
        .Stall_in(Stall_in), .En_out(En_out), .Finish_out(Finish_out),
        .CFG_out(CFG_out), .IM_out(IM_out), .Ctx_idx_out(Ctx_idx_out),
        .Busy_out(Busy_out), .Done_out(Done_out)
    );

    always #5 CLK = ~CLK;

    assign obs = {En_out, Finish_out, Busy_out, Done_out,
                  Ctx_idx_out, CFG_out, IM_out};

    task automatic write_ctx(input int a, input logic [55:0] d);
        Ctx_wr_en_in   = 1'b1;
        Ctx_wr_addr_in = 4'(a);
        Ctx_wr_data_in = d;
        @(negedge CLK);
        Ctx_wr_en_in = 1'b0;
        mm[a] = d;
    endtask

    task automatic do_run(input int last, input int loops, input int pct,
                          input logic [31:0] mask, input bit noise,
                          input bit swr, input string nm);
        int          idxq[$];
        int          n, issued, cyc, nl;
        bit          st;
        logic [63:0] exp;
        logic [3:0]  hidx;
        logic [23:0] hcfg;
        logic [31:0] him;
        logic [55:0] wd;
        nl = (loops == 0) ? 1 : loops;
        for (int it = 0; it < nl; it++)
            for (int i = 0; i <= last; i++) idxq.push_back(i);
        n = idxq.size();
        Mode_in     = 1'b1;
        Start_in    = 1'b1;
        Ctx_last_in = 4'(last);
        Loop_cnt_in = 16'(loops);
        wd = {24'($urandom), $urandom};
        if (swr) begin
            Ctx_wr_en_in   = 1'b1;
            Ctx_wr_addr_in = 4'd0;
            Ctx_wr_data_in = wd;
        end
        @(negedge CLK);
        if (swr) mm[0] = wd;
        Start_in     = 1'b0;
        Ctx_wr_en_in = 1'b0;
        Ctx_last_in  = 4'($urandom);
        Loop_cnt_in  = 16'($urandom);
        exp = {4'b0010, 60'h0};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s_start got=%h want=%h", nm, obs, exp);
        end
        hidx = 0; hcfg = 0; him = 0;
        issued = 0; cyc = 0;
        while (issued < n && cyc < 4 * n + 40) begin
            st = ((cyc < 32) && mask[cyc[4:0]]) || ($urandom_range(99) < pct);
            Stall_in = st;
            if (noise) begin
                Ctx_wr_en_in   = 1'($urandom_range(1));
                Ctx_wr_addr_in = ($urandom_range(1) == 1) ? 4'd0 : 4'($urandom);
                Ctx_wr_data_in = 56'h0000_0000_00AAAA;
                Start_in       = 1'($urandom_range(1));
                Ctx_last_in    = 4'($urandom);
                Loop_cnt_in    = 16'($urandom);
            end
            @(negedge CLK);
            if (!st) begin
                hidx = 4'(idxq[issued]);
                hcfg = mm[hidx][55:32];
                him  = mm[hidx][31:0];
            end
            exp = {!st, !st && issued == n - 1, !(!st && issued == n - 1),
                   1'b0, hidx, hcfg, him};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, obs, exp);
            end
            if (!st) issued++;
            cyc++;
        end
        Stall_in = 1'b0; Ctx_wr_en_in = 1'b0; Start_in = 1'b0;
        total++;
        if (issued != n) begin
            bad++;
            $display("FAIL %s_count got=%0d want=%0d", nm, issued, n);
        end
        @(negedge CLK);
        exp = {4'b0001, 60'h0};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s_done got=%h want=%h", nm, obs, exp);
        end
        @(negedge CLK);
        total++;
        if (obs !== 64'h0) begin
            bad++;
            $display("FAIL %s_idle got=%h want=0", nm, obs);
        end
    endtask

    task automatic test_reset;
        RST = 1'b0; Mode_in = 1'b0; Ctx_wr_en_in = 1'b0;
        Ctx_wr_addr_in = '0; Ctx_wr_data_in = '0; Start_in = 1'b0;
        Ctx_last_in = '0; Loop_cnt_in = '0; Stall_in = 1'b0;
        for (int i = 0; i < 16; i++) mm[i] = '0;
        @(negedge CLK);
        @(negedge CLK);
        total++;
        if (obs !== 64'h0) begin
            bad++;
            $display("FAIL reset got=%h want=0", obs);
        end
        RST = 1'b1;
        @(negedge CLK);
        total++;
        if (obs !== 64'h0) begin
            bad++;
            $display("FAIL reset_rel got=%h want=0", obs);
        end
    endtask

    task automatic test_basic;
        for (int i = 0; i < 3; i++)
            write_ctx(i, {24'(i + 1), 32'(16 * i)});
        do_run(2, 1, 0, 32'h0, 1'b0, 1'b0, "basic");
    endtask

    task automatic test_loops;
        do_run(1, 3, 0, 32'h0, 1'b0, 1'b0, "loops3");
        do_run(1, 0, 0, 32'h0, 1'b0, 1'b0, "loops0");
        do_run(0, 300, 10, 32'h0, 1'b0, 1'b1, "loops300");
    endtask

    task automatic test_stall;
        for (int i = 0; i < 4; i++)
            write_ctx(i, {24'($urandom), $urandom});
        do_run(3, 1, 0, 32'b110, 1'b0, 1'b0, "stall");
    endtask

    task automatic test_abort;
        Mode_in = 1'b1; Start_in = 1'b1;
        Ctx_last_in = 4'd3; Loop_cnt_in = 16'd2;
        @(negedge CLK);
        Start_in = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        Mode_in = 1'b0;
        @(negedge CLK);
        total++;
        if (obs !== 64'h0) begin
            bad++;
            $display("FAIL abort got=%h want=0", obs);
        end
        @(negedge CLK);
        total++;
        if (obs !== 64'h0) begin
            bad++;
            $display("FAIL abort_nodone got=%h want=0", obs);
        end
        write_ctx(0, 56'h12_3456_89AB_CDEF);
        write_ctx(1, 56'hFE_DCBA_7654_3210);
        do_run(1, 1, 0, 32'h0, 1'b0, 1'b0, "after_abort");
    endtask

    task automatic test_run_write;
        write_ctx(0, 56'h00_0001_0000_0005);
        do_run(1, 2, 20, 32'h0, 1'b1, 1'b0, "noise");
        do_run(1, 1, 0, 32'h0, 1'b0, 1'b0, "rerun");
    endtask

    task automatic test_start_mode0;
        Mode_in = 1'b0; Start_in = 1'b1;
        Ctx_last_in = 4'd2; Loop_cnt_in = 16'd1;
        @(negedge CLK);
        Start_in = 1'b0;
        total++;
        if (obs !== 64'h0) begin
            bad++;
            $display("FAIL mode0_start got=%h want=0", obs);
        end
        @(negedge CLK);
        total++;
        if (obs !== 64'h0) begin
            bad++;
            $display("FAIL mode0_idle got=%h want=0", obs);
        end
    endtask

    task automatic test_random;
        repeat (6) begin
            repeat (4) write_ctx($urandom_range(15), {24'($urandom), $urandom});
            do_run($urandom_range(15), $urandom_range(0, 4), 30, 32'h0,
                   1'b0, 1'($urandom_range(1)), "rand");
        end
    endtask

    task automatic test_reset_mid_run;
        for (int i = 0; i < 4; i++)
            write_ctx(i, {24'($urandom), $urandom});
        Mode_in = 1'b1; Start_in = 1'b1;
        Ctx_last_in = 4'd3; Loop_cnt_in = 16'd5;
        @(negedge CLK);
        Start_in = 1'b0;
        repeat (3) @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        total++;
        if (obs !== 64'h0) begin
            bad++;
            $display("FAIL rst_async got=%h want=0", obs);
        end
        for (int i = 0; i < 16; i++) mm[i] = '0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        do_run(3, 1, 0, 32'h0, 1'b0, 1'b0, "post_rst");
    endtask

    initial begin
        test_reset;
        test_basic;
        test_loops;
        test_stall;
        test_abort;
        test_run_write;
        test_start_mode0;
        test_random;
        test_reset_mid_run;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
